// File: rtl/mac_sequencer.sv
// mac_sequencer: control FSM that sequences one dot-product element
// C[i][j] = sum_k A[i][k]*B[k][j] on the TP1/TP2/AC datapath.
// Outputs are registered and decoded from the next state, so each state's
// output pattern is present during the cycle that state is occupied.
module mac_sequencer #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DIM_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [DIM_W-1:0]  dim,
    input  logic [ADDR_W-1:0] a_base,
    input  logic [ADDR_W-1:0] b_base,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ready,
    output logic [3:0]        reg_select,
    output logic              ac_clr,
    output logic              busy,
    output logic              done
);

    localparam int unsigned KW    = DIM_W + 1;
    localparam int unsigned SEL_W = 4;

    localparam logic [SEL_W-1:0] SEL_NONE = SEL_W'(0);
    localparam logic [SEL_W-1:0] SEL_TP1  = SEL_W'(1);
    localparam logic [SEL_W-1:0] SEL_TP2  = SEL_W'(2);
    localparam logic [SEL_W-1:0] SEL_AC   = SEL_W'(3);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLR    = 3'd1,
        S_RD_A   = 3'd2,
        S_LD_TP1 = 3'd3,
        S_RD_B   = 3'd4,
        S_LD_TP2 = 3'd5,
        S_MAC    = 3'd6,
        S_DONE   = 3'd7
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   a_ptr_q, a_ptr_d;
    logic [ADDR_W-1:0]   b_ptr_q, b_ptr_d;
    logic [DIM_W-1:0]    k_q, k_d;
    logic [DIM_W-1:0]    n_q, n_d;
    logic [KW-1:0]       k_inc;

    logic                mem_rd_q, mem_rd_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [SEL_W-1:0]    reg_select_q, reg_select_d;
    logic                ac_clr_q, ac_clr_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    // State, loop bookkeeping and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            a_ptr_q      <= '0;
            b_ptr_q      <= '0;
            k_q          <= '0;
            n_q          <= '0;
            mem_rd_q     <= 1'b0;
            mem_addr_q   <= '0;
            reg_select_q <= SEL_NONE;
            ac_clr_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_ptr_q      <= a_ptr_d;
            b_ptr_q      <= b_ptr_d;
            k_q          <= k_d;
            n_q          <= n_d;
            mem_rd_q     <= mem_rd_d;
            mem_addr_q   <= mem_addr_d;
            reg_select_q <= reg_select_d;
            ac_clr_q     <= ac_clr_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    // Next state, pointer updates and output decode of the next state
    always_comb begin
        state_d = state_q;
        a_ptr_d = a_ptr_q;
        b_ptr_d = b_ptr_q;
        k_d     = k_q;
        n_d     = n_q;
        // one extra bit so k+1 < n holds for n = 2^DIM_W-1
        k_inc   = {1'b0, k_q} + KW'(1);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CLR;
                    a_ptr_d = a_base;
                    b_ptr_d = b_base;
                    k_d     = '0;
                    n_d     = dim;
                end
            end
            S_CLR:    state_d = (n_q != '0) ? S_RD_A : S_DONE;
            S_RD_A:   if (mem_ready) state_d = S_LD_TP1;
            S_LD_TP1: state_d = S_RD_B;
            S_RD_B:   if (mem_ready) state_d = S_LD_TP2;
            S_LD_TP2: state_d = S_MAC;
            S_MAC: begin
                a_ptr_d = a_ptr_q + ADDR_W'(1);
                b_ptr_d = b_ptr_q + ADDR_W'(n_q);
                k_d     = k_q + DIM_W'(1);
                state_d = (k_inc < {1'b0, n_q}) ? S_RD_A : S_DONE;
            end
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        // abort drops any outstanding read and skips done
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end

        mem_rd_d     = 1'b0;
        mem_addr_d   = '0;
        reg_select_d = SEL_NONE;
        ac_clr_d     = 1'b0;
        busy_d       = (state_d != S_IDLE);
        done_d       = 1'b0;

        case (state_d)
            S_CLR:    ac_clr_d = 1'b1;
            S_RD_A: begin
                mem_rd_d   = 1'b1;
                mem_addr_d = a_ptr_d;
            end
            S_LD_TP1: reg_select_d = SEL_TP1;
            S_RD_B: begin
                mem_rd_d   = 1'b1;
                mem_addr_d = b_ptr_d;
            end
            S_LD_TP2: reg_select_d = SEL_TP2;
            S_MAC:    reg_select_d = SEL_AC;
            S_DONE:   done_d = 1'b1;
            default:  ;
        endcase
    end

    assign mem_rd     = mem_rd_q;
    assign mem_addr   = mem_addr_q;
    assign reg_select = reg_select_q;
    assign ac_clr     = ac_clr_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_mac_sequencer.sv
// tb_mac_sequencer: bench for mac_sequencer with a memory responder, a
// TP1/TP2/AC datapath and an arithmetic reference for addresses, timing and AC.
module tb_mac_sequencer;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DIM_W  = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [DIM_W-1:0]  dim = '0;
    logic [ADDR_W-1:0] a_base = '0;
    logic [ADDR_W-1:0] b_base = '0;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ready = 1'b0;
    logic [3:0]        reg_select;
    logic              ac_clr;
    logic              busy;
    logic              done;

    always #5 clk = ~clk;

    mac_sequencer #(.ADDR_W(ADDR_W), .DIM_W(DIM_W)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .dim(dim),
        .a_base(a_base), .b_base(b_base), .mem_rd(mem_rd), .mem_addr(mem_addr),
        .mem_ready(mem_ready), .reg_select(reg_select), .ac_clr(ac_clr),
        .busy(busy), .done(done)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Memory and environment state
    logic [7:0]        mem [256];
    int                wait_fixed = 0;
    int                wait_max   = 0;
    bit                noise      = 1'b0;
    int                wcnt = 0, cur_wait = 0, total_waits = 0;
    bit                rd_pending = 1'b0;
    logic [ADDR_W-1:0] last_addr = '0;
    int                rd_cycles = 0, clr_cycles = 0, addr_unstable = 0;
    int                addr_log[$];
    int                regsel_log[$];

    // Memory responder and output logger, acting between clock edges
    always @(negedge clk) begin
        if (mem_rd) begin
            rd_cycles++;
            if (rd_pending && (mem_addr != last_addr)) addr_unstable++;
            if (!rd_pending) begin
                cur_wait   = (wait_fixed >= 0) ? wait_fixed : int'($urandom_range(0, wait_max));
                wcnt       = 0;
                rd_pending = 1'b1;
            end
            last_addr = mem_addr;
            if (wcnt >= cur_wait) begin
                mem_ready   = 1'b1;
                rd_pending  = 1'b0;
                total_waits += cur_wait;
                addr_log.push_back(int'(mem_addr));
            end else begin
                mem_ready = 1'b0;
                wcnt++;
            end
        end else begin
            rd_pending = 1'b0;
            mem_ready  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        if (reg_select != 4'd0) regsel_log.push_back(int'(reg_select));
        if (ac_clr) clr_cycles++;
    end

    // Core datapath: read data register, TP1, TP2 and accumulator
    logic [7:0]  rd_data = '0, tp1 = '0, tp2 = '0;
    logic [31:0] ac = '0;
    always @(posedge clk) begin
        if (mem_rd && mem_ready) rd_data <= mem[mem_addr];
        if (reg_select == 4'd1) tp1 <= rd_data;
        if (reg_select == 4'd2) tp2 <= rd_data;
        if (ac_clr) ac <= '0;
        else if (reg_select == 4'd3) ac <= ac + 32'(tp1) * 32'(tp2);
    end

    // One full element; exp_done/exp_ac < 0 means take the reference model value
    task automatic run_elem(input string tag, input int d, input int a, input int b,
                            input int wf, input int wm, input bit nz,
                            input int exp_done, input longint exp_ac);
        int     done_cyc = -1;
        int     busy_bad = 0;
        int     mism;
        longint model_ac = 0;
        int     exp_addr[$];
        addr_log.delete();
        regsel_log.delete();
        rd_cycles = 0; clr_cycles = 0; addr_unstable = 0; total_waits = 0;
        wait_fixed = wf; wait_max = wm; noise = nz;
        @(negedge clk);
        dim = DIM_W'(d); a_base = ADDR_W'(a); b_base = ADDR_W'(b); start = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc <= 3000; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                start  = 1'b0;
                dim    = DIM_W'($urandom);
                a_base = ADDR_W'($urandom);
                b_base = ADDR_W'($urandom);
            end
            if (!busy) busy_bad++;
            if (done) begin
                done_cyc = cyc;
                break;
            end
        end
        for (int k = 0; k < d; k++) begin
            exp_addr.push_back((a + k) % 256);
            exp_addr.push_back((b + k * d) % 256);
            model_ac += longint'(mem[(a + k) % 256]) * longint'(mem[(b + k * d) % 256]);
        end
        if (exp_done < 0) exp_done = 2 + 5 * d + total_waits;
        if (exp_ac < 0) exp_ac = model_ac;
        check({tag, " done cycle"}, done_cyc, exp_done);
        check({tag, " AC"}, longint'(ac), exp_ac);
        check({tag, " busy low while running"}, busy_bad, 0);
        check({tag, " ac_clr cycles"}, clr_cycles, 1);
        check({tag, " mem_rd cycles"}, rd_cycles, 2 * d + total_waits);
        check({tag, " addr unstable"}, addr_unstable, 0);
        check({tag, " addr count"}, addr_log.size(), exp_addr.size());
        mism = 0;
        for (int i = 0; i < exp_addr.size() && i < addr_log.size(); i++)
            if (addr_log[i] != exp_addr[i]) mism++;
        check({tag, " addr mismatches"}, mism, 0);
        check({tag, " reg_select count"}, regsel_log.size(), 3 * d);
        mism = 0;
        for (int i = 0; i < regsel_log.size(); i++)
            if (regsel_log[i] != (i % 3) + 1) mism++;
        check({tag, " reg_select mismatches"}, mism, 0);
        @(negedge clk);
        check({tag, " idle busy"}, busy, 0);
        check({tag, " idle done"}, done, 0);
        noise = 1'b0;
    endtask

    typedef struct {
        string  tag;
        int     d;
        int     a;
        int     b;
        int     wf;
        int     exp_done;
        longint exp_ac;
    } vec_t;

    vec_t vecs[4];

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[8'h10] = 8'd1; mem[8'h11] = 8'd2; mem[8'h12] = 8'd3;
        mem[8'h40] = 8'd4; mem[8'h43] = 8'd5; mem[8'h46] = 8'd6;

        vecs[0] = '{"n3 zero-wait", 3, 'h10, 'h40, 0, 17, 32};
        vecs[1] = '{"n0",           0, 'h10, 'h40, 0,  2,  0};
        vecs[2] = '{"n2 wait3",     2, 'h20, 'h30, 3, 24, -1};
        vecs[3] = '{"wrap",         2, 'hFF, 'hFE, 0, 12, -1};

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset mem_rd", mem_rd, 0);
        check("reset mem_addr", mem_addr, 0);
        check("reset reg_select", reg_select, 0);
        check("reset ac_clr", ac_clr, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        rst = 1'b0;

        foreach (vecs[i])
            run_elem(vecs[i].tag, vecs[i].d, vecs[i].a, vecs[i].b, vecs[i].wf, 0, 1'b0,
                     vecs[i].exp_done, vecs[i].exp_ac);

        // abort in the second RD_B; start pulsed while busy must be ignored
        wait_fixed = 0; noise = 1'b0;
        @(negedge clk);
        dim = 4'd3; a_base = 8'h10; b_base = 8'h40; start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            case (c)
                1: start = 1'b0;
                4: start = 1'b1;
                5: begin
                    start = 1'b0;
                    check("busy-start ignored reg_select", reg_select, 2);
                end
                9: begin
                    check("abort point mem_rd", mem_rd, 1);
                    check("abort point mem_addr", mem_addr, 'h43);
                    abort = 1'b1;
                end
                10: begin
                    abort = 1'b0;
                    check("after abort busy", busy, 0);
                    check("after abort mem_rd", mem_rd, 0);
                    check("after abort reg_select", reg_select, 0);
                end
                default: ;
            endcase
            if (c >= 10) begin
                if (done || busy) check("no done/busy after abort", {done, busy}, 0);
            end
        end

        // start and abort together in IDLE: start wins; then abort from CLR
        @(negedge clk);
        dim = 4'd2; start = 1'b1; abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("start+abort ac_clr", ac_clr, 1);
        check("start+abort busy", busy, 1);
        @(negedge clk);
        abort = 1'b0;
        check("abort from CLR busy", busy, 0);

        // reset asserted in MAC, then a fresh element
        @(negedge clk);
        dim = 4'd2; a_base = 8'h05; b_base = 8'h50; start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (c == 6) begin
                check("pre-reset in MAC", reg_select, 3);
                rst = 1'b1;
            end
            if (c == 7) begin
                check("mid-MAC reset outputs",
                      {mem_rd, mem_addr, reg_select, ac_clr, busy, done}, 0);
                rst = 1'b0;
            end
        end
        run_elem("after reset", 2, 'h05, 'h50, 0, 0, 1'b0, 12, -1);

        // largest dimension
        run_elem("n15", 15, 'h80, 'h03, 0, 0, 1'b0, 77, -1);

        // randomized elements with random wait states and mem_ready noise
        for (int r = 0; r < 25; r++) begin
            run_elem($sformatf("rand%0d", r), int'($urandom_range(0, 5)),
                     int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                     -1, 3, 1'b1, -1, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
